decoder_seq_onehot: RTL and testbench
=====================================

Name: decoder_seq_onehot

Overview:
- Parametrised, registered binary-to-one-hot decoder with a valid/ready command interface; generalises the fixed 3-to-8 combinational decoder.
- Three modes:
  - STATIC: hold the decoded line.
  - PULSE: assert the decoded line for a programmed number of cycles.
  - SCAN: walk the one-hot output from a start index to a last index, with programmable dwell per step.
- Drives chip/row selects, LED/segment strobes and mux enables from sequencer logic.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable).
- CNT_W, 8, width of pulse_len and the internal dwell counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  output enable; 0 forces y to zero (registered, 1-cycle latency); FSM and counters unaffected.
- mode  in  2  00 STATIC, 01 PULSE, 10 SCAN, 11 treated as STATIC; sampled only on accept.
- sel  in  SEL_W  decode index (STATIC/PULSE) or scan start index (SCAN); sampled on accept.
- pulse_len  in  CNT_W  PULSE: active cycles; SCAN: dwell cycles per step; 0 is treated as 1; sampled on accept.
- scan_last  in  SEL_W  last index shown in SCAN; sampled on accept.
- sel_valid  in  1  command valid.
- sel_ready  out  1  equals !busy; accept = sel_valid && sel_ready at a clock edge.
- y  out  OUT_W  registered one-hot output, or all zero.
- busy  out  1  high while PULSE or SCAN is in progress.
- done  out  1  one-cycle pulse when PULSE or SCAN completes.

Behaviour:
- Reset (rst_n low at an edge), including mid-operation:
  - y=0, busy=0, done=0, sel_ready=1.
  - FSM goes to IDLE, counters and index are cleared, and any in-flight PULSE/SCAN is abandoned with no done.
- FSM states:
  - IDLE -> HOLD on STATIC accept.
  - IDLE or HOLD -> PULSE or SCAN on the corresponding accept.
  - PULSE or SCAN -> IDLE on completion.
  - HOLD -> HOLD on a new STATIC accept.
- All outputs are registered. y_next = en ? decoded : 0.
- STATIC, accept at edge k:
  - From edge k+1, y = 1<<sel, held until the next accept.
  - busy stays 0 and done never pulses.
- PULSE, accept at edge k with length L (L=0 becomes 1):
  - y = 1<<sel for exactly L cycles, from the output of edge k through edge k+L-1.
  - At edge k+L: y=0, done=1 for that cycle, busy=0, state IDLE.
  - busy=1 on the outputs of edges k..k+L-1.
- SCAN, accept at edge k:
  - idx starts at sel. Each step drives y = 1<<idx for L cycles, then idx = idx+1 modulo OUT_W (OUT_W-1 wraps to 0).
  - Completes after the step where idx == scan_last. Total steps = ((scan_last - sel) mod OUT_W) + 1.
  - sel == scan_last gives a single step.
  - Step transitions are seamless: no zero gap between adjacent one-hot values.
  - After the final step: y=0, done=1 for one cycle, busy=0, same timing rule as PULSE.
- While busy:
  - sel_ready=0; sel_valid is ignored and no queueing occurs.
  - Changes on mode, sel, pulse_len and scan_last have no effect.
- Done cycle: sel_ready=1, so a new command accepted on the edge ending the done cycle starts normally. Its y appears on the next edge and done drops.
- en=0 during PULSE or SCAN:
  - y is zero from the next edge.
  - Timing and done are unchanged.
  - Re-enabling shows the current index.
- y is always one-hot or zero. It is never multi-hot, including on wrap and mode transitions.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with sel_valid=1 -> y=0, busy=0, done=0, sel_ready=1 throughout; first accept only after release.
- STATIC, SEL_W=3: sel=5 accepted -> y=8'b0010_0000 next cycle and held 20 cycles. Then sel=0 -> y=8'b0000_0001. Toggle en=0 -> y=0 one cycle later; en=1 -> y=8'b0000_0001.
- PULSE:
  - sel=2, pulse_len=4 -> y=8'b0000_0100 for exactly 4 cycles, then y=0 with done=1 one cycle; sel_valid during busy ignored.
  - pulse_len=0 -> 1-cycle pulse.
- SCAN with wrap: sel=6, scan_last=1, pulse_len=2 -> y sequence 0x40,0x40,0x80,0x80,0x01,0x01,0x02,0x02, then 0 with done=1; no multi-hot, no gaps.
- Back-to-back: new PULSE command held valid during the done cycle -> accepted at that edge, next pulse starts immediately; done is high exactly one cycle.
- Mid-operation reset: rst_n=0 in the third step of a SCAN -> y=0, busy=0, no done; a SCAN accepted after release runs complete and correct. Repeat with SEL_W=4: sel=15, scan_last=0 -> 0x8000 then 0x0001.

Source files
------------

// File: rtl/decoder_seq_onehot_if.sv
// Command/status bundle for decoder_seq_onehot: command fields, valid/ready handshake,
// one-hot output and progress flags.
interface decoder_seq_onehot_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] pulse_len;
    logic [SEL_W-1:0] scan_last;
    logic             sel_valid;
    logic             sel_ready;
    logic [OUT_W-1:0] y;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sel, pulse_len, scan_last, sel_valid,
        input  sel_ready, y, busy, done
    );

    modport slave (
        input  en, mode, sel, pulse_len, scan_last, sel_valid,
        output sel_ready, y, busy, done
    );
endinterface

// File: rtl/decoder_seq_onehot.sv
// Registered binary-to-one-hot decoder with STATIC hold, timed PULSE and dwell-stepped SCAN
// modes, driven through a valid/ready command interface.
module decoder_seq_onehot #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_seq_onehot_if.slave bus
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {StIdle, StHold, StPulse, StScan} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [CNT_W-1:0] len_m1;

    assign accept = bus.sel_valid && !busy_q;
    // Counters hold "cycles remaining minus one", so a zero length collapses to one cycle.
    assign len_m1 = (bus.pulse_len == '0) ? '0 : bus.pulse_len - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    idx_d   = bus.sel;
                    last_d  = bus.scan_last;
                    cnt_d   = len_m1;
                    dwell_d = len_m1;
                    unique case (bus.mode)
                        2'b01: begin
                            state_d = StPulse;
                            busy_d  = 1'b1;
                        end
                        2'b10: begin
                            state_d = StScan;
                            busy_d  = 1'b1;
                        end
                        default: state_d = StHold;
                    endcase
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StScan: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == last_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Natural SEL_W-bit overflow gives the OUT_W-1 -> 0 wrap.
                    idx_d = idx_q + SEL_W'(1);
                    cnt_d = dwell_q;
                end
            end
            default: state_d = StIdle;
        endcase
        y_d = (bus.en && state_d != StIdle) ? (OUT_W'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sel_ready = !busy_q;
endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Bench for decoder_seq_onehot: directed cycle table on an 8-output instance, a short
// sequence on a 16-output instance, then randomized traffic against a trace-based model.
module tb_decoder_seq_onehot;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst3_n;
    logic rst4_n;

    decoder_seq_onehot_if #(.SEL_W(3), .CNT_W(8)) b3 ();
    decoder_seq_onehot_if #(.SEL_W(4), .CNT_W(8)) b4 ();

    decoder_seq_onehot #(.SEL_W(3), .CNT_W(8)) dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (b3.slave)
    );

    decoder_seq_onehot #(.SEL_W(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (b4.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       valid;
        logic [1:0] mode;
        logic [2:0] sel;
        logic [7:0] len;
        logic [2:0] last;
        int         reps;
        logic [7:0] y;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic e, input logic va, input logic [1:0] m,
                               input logic [2:0] s, input logic [7:0] l, input logic [2:0] la,
                               input int reps, input logic [7:0] ey, input logic eb,
                               input logic ed);
        vec_t t;
        t.rst_n = r;  t.en = e;    t.valid = va; t.mode = m; t.sel = s; t.len = l;
        t.last = la;  t.reps = reps; t.y = ey;   t.busy = eb; t.done = ed;
        return t;
    endfunction

    task automatic drive3(input logic r, input logic e, input logic va, input logic [1:0] m,
                          input logic [2:0] s, input logic [7:0] l, input logic [2:0] la);
        rst3_n = r; b3.en = e; b3.sel_valid = va; b3.mode = m;
        b3.sel = s; b3.pulse_len = l; b3.scan_last = la;
    endtask

    task automatic apply4(input logic r, input logic va, input logic [1:0] m,
                          input logic [3:0] s, input logic [3:0] la, input logic [15:0] ey,
                          input logic eb, input logic ed);
        @(negedge clk);
        rst4_n = r; b4.en = 1'b1; b4.sel_valid = va; b4.mode = m;
        b4.sel = s; b4.pulse_len = 8'd1; b4.scan_last = la;
        @(posedge clk);
        #1;
        check("w4_y", 32'(b4.y), 32'(ey));
        check("w4_busy", 32'(b4.busy), 32'(eb));
        check("w4_done", 32'(b4.done), 32'(ed));
    endtask

    // Reference model: a command expands into the full per-cycle list of shown indices.
    int   sched[$];
    int   m_shown;
    logic m_busy;
    logic m_done;

    task automatic model_step(input logic r, input logic va, input logic [1:0] m,
                              input logic [2:0] s, input logic [7:0] l, input logic [2:0] la);
        int len;
        int steps;
        m_done = 1'b0;
        if (!r) begin
            sched.delete();
            m_shown = -1;
            m_busy  = 1'b0;
        end else if (m_busy) begin
            if (sched.size() > 0) begin
                m_shown = sched.pop_front();
            end else begin
                m_shown = -1;
                m_busy  = 1'b0;
                m_done  = 1'b1;
            end
        end else if (va) begin
            len = (l == 8'd0) ? 1 : int'(l);
            if (m == 2'b01) begin
                for (int i = 0; i < len; i++) sched.push_back(int'(s));
            end else if (m == 2'b10) begin
                steps = ((int'(la) - int'(s) + 8) % 8) + 1;
                for (int st = 0; st < steps; st++)
                    for (int i = 0; i < len; i++) sched.push_back((int'(s) + st) % 8);
            end
            if (m == 2'b01 || m == 2'b10) begin
                m_shown = sched.pop_front();
                m_busy  = 1'b1;
            end else begin
                m_shown = int'(s);
            end
        end
    endtask

    initial begin
        logic       r, e, va;
        logic [1:0] m;
        logic [2:0] s, la;
        logic [7:0] l;
        logic [7:0] ey;

        drive3(1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 8'd0, 3'd0);
        rst4_n = 1'b0; b4.en = 1'b1; b4.sel_valid = 1'b0; b4.mode = 2'b00;
        b4.sel = '0; b4.pulse_len = '0; b4.scan_last = '0;

        //                 rst en vld mode sel len last reps  y    busy done
        vecs.push_back(v(1'b0, 1, 1, 2'd0, 3'd5, 8'd0, 3'd0, 3, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd0, 3'd5, 8'd0, 3'd0, 1, 8'h20, 0, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd1, 8'd0, 3'd0, 20, 8'h20, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h01, 0, 0));
        vecs.push_back(v(1'b1, 0, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h01, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd1, 3'd2, 8'd4, 3'd0, 1, 8'h04, 1, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd0, 3'd7, 8'd9, 3'd0, 3, 8'h04, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd1, 3'd3, 8'd0, 3'd0, 1, 8'h08, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd2, 3'd6, 8'd2, 3'd1, 1, 8'h40, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h40, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 2, 8'h80, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 2, 8'h01, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 2, 8'h02, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        // back-to-back: second PULSE held valid through the done cycle
        vecs.push_back(v(1'b1, 1, 1, 2'd1, 3'd1, 8'd2, 3'd0, 1, 8'h02, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h02, 1, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd1, 3'd4, 8'd1, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 1, 2'd1, 3'd4, 8'd1, 3'd0, 1, 8'h10, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        // reset in the third step of a SCAN, then a fresh SCAN
        vecs.push_back(v(1'b1, 1, 1, 2'd2, 3'd0, 8'd1, 3'd7, 1, 8'h01, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h02, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h04, 1, 0));
        vecs.push_back(v(1'b0, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 2, 8'h00, 0, 0));
        vecs.push_back(v(1'b1, 1, 1, 2'd2, 3'd3, 8'd1, 3'd4, 1, 8'h08, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h10, 1, 0));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 1));
        vecs.push_back(v(1'b1, 1, 0, 2'd0, 3'd0, 8'd0, 3'd0, 1, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                @(negedge clk);
                drive3(vecs[i].rst_n, vecs[i].en, vecs[i].valid, vecs[i].mode, vecs[i].sel,
                       vecs[i].len, vecs[i].last);
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_y", i), 32'(b3.y), 32'(vecs[i].y));
                check($sformatf("vec%0d_busy", i), 32'(b3.busy), 32'(vecs[i].busy));
                check($sformatf("vec%0d_done", i), 32'(b3.done), 32'(vecs[i].done));
                check($sformatf("vec%0d_ready", i), 32'(b3.sel_ready), 32'(!vecs[i].busy));
            end
        end

        // 16-output instance: interrupted SCAN, then the 15 -> 0 wrap
        apply4(1'b0, 1'b1, 2'd2, 4'd12, 4'd3, 16'h0000, 1'b0, 1'b0);
        apply4(1'b1, 1'b1, 2'd2, 4'd12, 4'd3, 16'h1000, 1'b1, 1'b0);
        apply4(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 16'h2000, 1'b1, 1'b0);
        apply4(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        apply4(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        apply4(1'b1, 1'b1, 2'd2, 4'd15, 4'd0, 16'h8000, 1'b1, 1'b0);
        apply4(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 16'h0001, 1'b1, 1'b0);
        apply4(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        apply4(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);

        // randomized traffic, starting from a reset so model and DUT agree
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r  = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 7) != 0);
            va = ($urandom_range(0, 2) == 0);
            m  = 2'($urandom_range(0, 3));
            s  = 3'($urandom_range(0, 7));
            l  = 8'($urandom_range(0, 4));
            la = 3'($urandom_range(0, 7));
            drive3(r, e, va, m, s, l, la);
            model_step(r, va, m, s, l, la);
            ey = (r && e && m_shown >= 0) ? (8'd1 << m_shown) : 8'd0;
            @(posedge clk);
            #1;
            check("rnd_y", 32'(b3.y), 32'(ey));
            check("rnd_busy", 32'(b3.busy), 32'(m_busy));
            check("rnd_done", 32'(b3.done), 32'(m_done));
            check("rnd_ready", 32'(b3.sel_ready), 32'(!m_busy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
